// File: rtl/rd_ptr_ctrl_if.sv
// Read-side FIFO pointer bus: consumer request, raw write Gray pointer in,
// RAM address, status flags and Gray read pointer out.
interface rd_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   wr_ptr_g_async;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rd_ptr_g;
    logic                  fifo_empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  underflow;

    // Consumer / write-domain side.
    modport master (
        output rd_en, wr_ptr_g_async,
        input  rd_addr, rd_ptr_g, fifo_empty, almost_empty, rd_count, underflow
    );

    // Pointer controller side.
    modport slave (
        input  rd_en, wr_ptr_g_async,
        output rd_addr, rd_ptr_g, fifo_empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer controller for an async FIFO: synchronises the write Gray
// pointer and derives read address, Gray read pointer, fill count and flags.
module rd_ptr_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic         rd_clk,
    input  logic         rd_rst_n,
    rd_ptr_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t sync_q [SYNC_STAGES];
    ptr_t wr_g_s;
    ptr_t wr_b_s;

    ptr_t rd_ptr_b;
    ptr_t rd_ptr_g_q;
    ptr_t rd_count_q;
    logic fifo_empty_q;
    logic almost_empty_q;
    logic underflow_q;

    logic rd_inc;
    ptr_t rd_ptr_b_next;
    ptr_t cnt_next;

    // NOTE: the synchroniser flops are reset too; a stale pointer left in the
    // chain would make the FIFO look non-empty right after reset.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep this a true shift chain; with
            // blocking ones every stage would collapse onto the input.
            sync_q[0] <= bus.wr_ptr_g_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_g_s = sync_q[SYNC_STAGES-1];
    assign wr_b_s = gray2bin(wr_g_s);

    // NOTE: every output of this block is assigned on all paths, so no latch.
    always_comb begin
        rd_inc        = bus.rd_en & ~fifo_empty_q;
        rd_ptr_b_next = rd_ptr_b + ptr_t'(rd_inc);
        cnt_next      = wr_b_s - rd_ptr_b_next;
    end

    // The read and any newly synchronised write are folded into one count here.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_ptr_b       <= '0;
            rd_ptr_g_q     <= '0;
            rd_count_q     <= '0;
            fifo_empty_q   <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            rd_ptr_b       <= rd_ptr_b_next;
            rd_ptr_g_q     <= bin2gray(rd_ptr_b_next);
            rd_count_q     <= cnt_next;
            fifo_empty_q   <= (cnt_next == '0);
            almost_empty_q <= (cnt_next <= ptr_t'(AEMPTY_THRESH));
            underflow_q    <= bus.rd_en & fifo_empty_q;
        end
    end

    assign bus.rd_addr      = rd_ptr_b[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_g     = rd_ptr_g_q;
    assign bus.rd_count     = rd_count_q;
    assign bus.fifo_empty   = fifo_empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against an occupancy-based reference model.
module tb_rd_ptr_ctrl;
    localparam int AW     = 4;
    localparam int PW     = AW + 1;
    localparam int S      = 2;
    localparam int TH     = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int PMOD   = 1 << PW;

    logic rd_clk = 1'b0;
    logic rd_rst_n = 1'b0;
    rd_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    rd_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(S), .AEMPTY_THRESH(TH)) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (bus.slave)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: reads taken so far (mod PMOD) and write positions
    // visible to the read domain, delayed S edges through a queue.
    int m_rd;
    int m_count;
    bit m_empty;
    bit m_uf;
    int wr_seen_q[$];

    typedef struct {
        logic rst_n;
        logic rd_en;
        int   wr_b;
        int   e_count;
        logic e_empty;
        logic e_ae;
        logic e_uf;
        int   e_addr;
    } vec_t;

    vec_t vecs[14];

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0;
        m_count = 0;
        m_empty = 1'b1;
        m_uf = 1'b0;
        wr_seen_q.delete();
        repeat (S) wr_seen_q.push_back(0);
    endtask

    // Drive one cycle, advance the model at the edge, then compare everything.
    task automatic step(input logic rst_n_i, input logic en_i, input int wr_b_i);
        int seen;
        rd_rst_n = rst_n_i;
        bus.rd_en = en_i;
        bus.wr_ptr_g_async = PW'(gray(wr_b_i));
        @(posedge rd_clk);
        if (!rst_n_i) begin
            model_reset();
        end else begin
            seen = wr_seen_q.pop_front();
            wr_seen_q.push_back(wr_b_i);
            m_uf = en_i && m_empty;
            if (en_i && !m_empty) m_rd = (m_rd + 1) % PMOD;
            m_count = (seen - m_rd + PMOD) % PMOD;
            m_empty = (m_count == 0);
        end
        #1;
        check("rd_addr", int'(bus.rd_addr), m_rd % DEPTH);
        check("rd_ptr_g", int'(bus.rd_ptr_g), gray(m_rd));
        check("rd_count", int'(bus.rd_count), m_count);
        check("fifo_empty", int'(bus.fifo_empty), int'(m_empty));
        check("almost_empty", int'(bus.almost_empty), int'(m_count <= TH));
        check("underflow", int'(bus.underflow), int'(m_uf));
    endtask

    int wr_b;
    int guard;
    int rd_pct;
    int wr_pct;
    int exp_g[3];
    int exp_a[3];

    initial begin
        model_reset();
        bus.rd_en = 1'b0;
        bus.wr_ptr_g_async = '0;

        // rst_n, rd_en, wr_b | count, empty, ae, uf, addr (after the edge)
        vecs[0]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 3, 3, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b1, 3, 2, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b0, 2};
        vecs[11] = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b0, 3};
        vecs[12] = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 3};
        vecs[13] = '{1'b1, 1'b0, 3, 0, 1'b1, 1'b1, 1'b0, 3};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst_n, vecs[i].rd_en, vecs[i].wr_b);
            check("vec_count", int'(bus.rd_count), vecs[i].e_count);
            check("vec_empty", int'(bus.fifo_empty), int'(vecs[i].e_empty));
            check("vec_aempty", int'(bus.almost_empty), int'(vecs[i].e_ae));
            check("vec_underflow", int'(bus.underflow), int'(vecs[i].e_uf));
            check("vec_addr", int'(bus.rd_addr), vecs[i].e_addr);
        end

        // Wrap: walk both pointers up to 30, then writer wraps to binary 1.
        wr_b = 3;
        guard = 0;
        while (m_rd != 30 && guard < 200) begin
            if (wr_b != 30) wr_b = wr_b + 1;
            step(1'b1, 1'b1, wr_b);
            guard++;
        end
        check("wrap_preload_reached", m_rd, 30);
        for (int i = 0; i < 3; i++) begin
            wr_b = (wr_b + 1) % PMOD;
            step(1'b1, 1'b0, wr_b);
        end
        repeat (S + 1) step(1'b1, 1'b0, wr_b);
        check("wrap_count", int'(bus.rd_count), 3);
        check("wrap_addr_start", int'(bus.rd_addr), 14);
        exp_g = '{5'b10000, 5'b00000, 5'b00001};
        exp_a = '{15, 0, 1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, wr_b);
            check("wrap_ptr_g", int'(bus.rd_ptr_g), exp_g[i]);
            check("wrap_addr", int'(bus.rd_addr), exp_a[i]);
        end
        check("wrap_empty", int'(bus.fifo_empty), 1);

        // Full fill: rd pointer 0, writer at binary 16.
        step(1'b0, 1'b0, 0);
        for (wr_b = 1; wr_b <= DEPTH; wr_b++) step(1'b1, 1'b0, wr_b);
        wr_b = DEPTH;
        repeat (S + 1) step(1'b1, 1'b0, wr_b);
        check("full_count", int'(bus.rd_count), DEPTH);
        check("full_empty", int'(bus.fifo_empty), 0);
        check("full_aempty", int'(bus.almost_empty), 0);

        // Mid-drain reset with count 5.
        repeat (DEPTH - 5) step(1'b1, 1'b1, wr_b);
        check("drain_count", int'(bus.rd_count), 5);
        step(1'b0, 1'b1, wr_b);
        check("mrst_addr", int'(bus.rd_addr), 0);
        check("mrst_ptr_g", int'(bus.rd_ptr_g), 0);
        check("mrst_empty", int'(bus.fifo_empty), 1);
        check("mrst_count", int'(bus.rd_count), 0);
        for (int i = 0; i < S; i++) begin
            step(1'b1, 1'b0, wr_b);
            check("mrst_empty_hold", int'(bus.fifo_empty), 1);
        end
        step(1'b1, 1'b0, wr_b);
        check("mrst_empty_release", int'(bus.fifo_empty), 0);
        check("mrst_count_release", int'(bus.rd_count), DEPTH);

        // Randomized traffic with changing read/write pressure and rare resets.
        step(1'b0, 1'b0, 0);
        wr_b = 0;
        for (int i = 0; i < 1800; i++) begin
            case ((i / 300) % 3)
                0:       begin rd_pct = 20; wr_pct = 80; end
                1:       begin rd_pct = 80; wr_pct = 20; end
                default: begin rd_pct = 50; wr_pct = 50; end
            endcase
            if ($urandom_range(0, 299) == 0) begin
                wr_b = 0;
                step(1'b0, 1'($urandom_range(0, 1)), wr_b);
            end else begin
                if ($urandom_range(0, 99) < wr_pct && ((wr_b - m_rd + PMOD) % PMOD) < DEPTH)
                    wr_b = (wr_b + 1) % PMOD;
                step(1'b1, 1'($urandom_range(0, 99) < rd_pct), wr_b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
